// File: rtl/sbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sbox_pkg
// Brief    : Side indices, route-select encodings and config field lookup
//            shared by the switch box and its track multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package sbox_pkg;

    typedef enum logic [1:0] {
        SIDE_N = 2'd0,
        SIDE_E = 2'd1,
        SIDE_S = 2'd2,
        SIDE_W = 2'd3
    } side_e;

    localparam logic [1:0] SEL_OFF      = 2'd0;
    localparam logic [1:0] SEL_CW       = 2'd1;
    localparam logic [1:0] SEL_STRAIGHT = 2'd2;
    localparam logic [1:0] SEL_CCW      = 2'd3;

    // LSB of the 2-bit select field for a given side/track in the config word
    function automatic int cfg_idx(input int side, input int track, input int w);
        return 2 * (side * w + track);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_track_mux.sv
`default_nettype none
// ============================================================================
// Module   : sbox_track_mux
// Brief    : One outgoing track: picks clockwise, straight or rotated
//            counter-clockwise source (or off) from a 2-bit select.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_track_mux
    import sbox_pkg::*;
#(
    parameter int W     = 2,
    parameter int TRACK = 0
) (
    input  logic [1:0]   i_sel,
    input  logic [W-1:0] i_cw_src,
    input  logic [W-1:0] i_st_src,
    input  logic [W-1:0] i_ccw_src,
    output logic         o_out,
    output logic         o_oe
);

    // Mask-and-reduce picks one bit while keeping every bus bit referenced
    localparam logic [W-1:0] c_same_mask = W'(1) << TRACK;
    localparam logic [W-1:0] c_next_mask = W'(1) << ((TRACK + 1) % W);

    logic w_cw;
    logic w_st;
    logic w_ccw;

    assign w_cw  = |(i_cw_src  & c_same_mask);
    assign w_st  = |(i_st_src  & c_same_mask);
    assign w_ccw = |(i_ccw_src & c_next_mask);

    always_comb begin
        o_out = 1'b0;
        o_oe  = 1'b0;
        case (i_sel)
            SEL_CW:       begin o_out = w_cw;  o_oe = 1'b1; end
            SEL_STRAIGHT: begin o_out = w_st;  o_oe = 1'b1; end
            SEL_CCW:      begin o_out = w_ccw; o_oe = 1'b1; end
            default:      begin o_out = 1'b0;  o_oe = 1'b0; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/switch_box_param.sv
`default_nettype none
// ============================================================================
// Module   : switch_box_param
// Brief    : W-track switch box with serial shadow config chain and atomic
//            commit to the active routing register.
// Options  : SBOX_OUTPUT_REG_EN - register *_out/*_oe (one cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module switch_box_param
    import sbox_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_en,
    input  logic         cfg_in,
    output logic         cfg_out,
    input  logic         cfg_commit,
    output logic         cfg_full,
    output logic         cfg_err,
    input  logic [W-1:0] north_in,
    input  logic [W-1:0] east_in,
    input  logic [W-1:0] south_in,
    input  logic [W-1:0] west_in,
    output logic [W-1:0] north_out,
    output logic [W-1:0] east_out,
    output logic [W-1:0] south_out,
    output logic [W-1:0] west_out,
    output logic [W-1:0] north_oe,
    output logic [W-1:0] east_oe,
    output logic [W-1:0] south_oe,
    output logic [W-1:0] west_oe
);

    localparam int CFG_BITS = 8 * W;
    localparam int c_cnt_w  = $clog2(CFG_BITS + 2);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(CFG_BITS);
    localparam logic [c_cnt_w-1:0] c_over = c_cnt_w'(CFG_BITS + 1);

    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_active;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (cfg_en) begin
                r_shadow <= {cfg_in, r_shadow[CFG_BITS-1:1]};
            end
            // Commit sees the pre-shift shadow and restarts the length count
            if (cfg_commit) begin
                r_active <= r_shadow;
                r_count  <= cfg_en ? c_cnt_w'(1) : '0;
                r_err    <= (r_count != c_full);
            end else if (cfg_en) begin
                if (r_count == c_full) begin
                    r_count <= c_over;
                    r_err   <= 1'b1;
                end else if (r_count != c_over) begin
                    r_count <= r_count + c_cnt_w'(1);
                end
            end
        end
    end

    assign cfg_out  = r_shadow[0];
    assign cfg_full = (r_count == c_full);
    assign cfg_err  = r_err;

    // Side s occupies bits [s*W +: W] of the flattened buses
    logic [4*W-1:0] w_in;
    logic [4*W-1:0] w_rout;
    logic [4*W-1:0] w_roe;
    logic [4*W-1:0] w_out;
    logic [4*W-1:0] w_oe;

    assign w_in[int'(SIDE_N)*W +: W] = north_in;
    assign w_in[int'(SIDE_E)*W +: W] = east_in;
    assign w_in[int'(SIDE_S)*W +: W] = south_in;
    assign w_in[int'(SIDE_W)*W +: W] = west_in;

    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar i = 0; i < W; i++) begin : g_track
            sbox_track_mux #(
                .W     (W),
                .TRACK (i)
            ) u_mux (
                .i_sel     (r_active[cfg_idx(s, i, W) +: 2]),
                .i_cw_src  (w_in[((s + 1) % 4) * W +: W]),
                .i_st_src  (w_in[((s + 2) % 4) * W +: W]),
                .i_ccw_src (w_in[((s + 3) % 4) * W +: W]),
                .o_out     (w_rout[s*W + i]),
                .o_oe      (w_roe[s*W + i])
            );
        end
    end

`ifdef SBOX_OUTPUT_REG_EN
    logic [4*W-1:0] r_out;
    logic [4*W-1:0] r_oe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
            r_oe  <= '0;
        end else begin
            r_out <= w_rout;
            r_oe  <= w_roe;
        end
    end

    assign w_out = r_out;
    assign w_oe  = r_oe;
`else
    assign w_out = w_rout;
    assign w_oe  = w_roe;
`endif

    assign north_out = w_out[int'(SIDE_N)*W +: W];
    assign east_out  = w_out[int'(SIDE_E)*W +: W];
    assign south_out = w_out[int'(SIDE_S)*W +: W];
    assign west_out  = w_out[int'(SIDE_W)*W +: W];
    assign north_oe  = w_oe[int'(SIDE_N)*W +: W];
    assign east_oe   = w_oe[int'(SIDE_E)*W +: W];
    assign south_oe  = w_oe[int'(SIDE_S)*W +: W];
    assign west_oe   = w_oe[int'(SIDE_W)*W +: W];

endmodule
`default_nettype wire

// File: tb/tb_switch_box_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_box_param
// Brief    : Scoreboard bench for a W=2 and a W=1 switch box sharing clk/rst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_box_param;

    logic clk;
    logic rst;

    // W=2 instance
    logic       cfg_en, cfg_in, cfg_commit, cfg_out, cfg_full, cfg_err;
    logic [1:0] north_in, east_in, south_in, west_in;
    logic [1:0] north_out, east_out, south_out, west_out;
    logic [1:0] north_oe, east_oe, south_oe, west_oe;

    // W=1 instance
    logic       c1_en, c1_in, c1_commit, c1_out, c1_full, c1_err;
    logic [0:0] n1_in, e1_in, s1_in, w1_in;
    logic [0:0] n1_out, e1_out, s1_out, w1_out;
    logic [0:0] n1_oe, e1_oe, s1_oe, w1_oe;

    switch_box_param #(.W(2)) dut (
        .clk(clk), .rst(rst),
        .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out),
        .cfg_commit(cfg_commit), .cfg_full(cfg_full), .cfg_err(cfg_err),
        .north_in(north_in), .east_in(east_in), .south_in(south_in), .west_in(west_in),
        .north_out(north_out), .east_out(east_out), .south_out(south_out), .west_out(west_out),
        .north_oe(north_oe), .east_oe(east_oe), .south_oe(south_oe), .west_oe(west_oe)
    );

    switch_box_param #(.W(1)) dut1 (
        .clk(clk), .rst(rst),
        .cfg_en(c1_en), .cfg_in(c1_in), .cfg_out(c1_out),
        .cfg_commit(c1_commit), .cfg_full(c1_full), .cfg_err(c1_err),
        .north_in(n1_in), .east_in(e1_in), .south_in(s1_in), .west_in(w1_in),
        .north_out(n1_out), .east_out(e1_out), .south_out(s1_out), .west_out(w1_out),
        .north_oe(n1_oe), .east_oe(e1_oe), .south_oe(s1_oe), .west_oe(w1_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation: {W=2 fields (19 bits), W=1 fields (11 bits)}
    localparam logic [18:0] MA = 19'h7FFFF;
    localparam logic [18:0] MR = {16'hFFFF, 3'b000};
    localparam logic [18:0] MC = 19'b111;

    int    checks = 0;
    int    errors = 0;
    string       q_name[$];
    logic [29:0] q_exp[$];
    logic [29:0] q_mask[$];

    string       mon_nm;
    logic [29:0] mon_e, mon_m, mon_o;

    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            mon_nm = q_name.pop_front();
            mon_e  = q_exp.pop_front();
            mon_m  = q_mask.pop_front();
            mon_o  = {north_out, east_out, south_out, west_out,
                      north_oe, east_oe, south_oe, west_oe,
                      cfg_out, cfg_full, cfg_err,
                      n1_out, e1_out, s1_out, w1_out,
                      n1_oe, e1_oe, s1_oe, w1_oe,
                      c1_out, c1_full, c1_err};
            checks++;
            if ((mon_o & mon_m) !== (mon_e & mon_m)) begin
                errors++;
                $display("FAIL %s: got %h want %h (mask %h)", mon_nm, mon_o & mon_m, mon_e & mon_m, mon_m);
            end
        end
    end

    function automatic logic [18:0] v2(input logic [1:0] no, eo, so, wo, noe, eoe, soe, woe,
                                       input logic co, fu, er);
        return {no, eo, so, wo, noe, eoe, soe, woe, co, fu, er};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic [29:0] e, input logic [29:0] m);
        q_name.push_back(nm);
        q_exp.push_back(e);
        q_mask.push_back(m);
    endtask

    // An idle edge first lets registered outputs catch up; state holds meanwhile
    task automatic chk2(input string nm, input logic [18:0] e, input logic [18:0] m);
        tick();
        push(nm, {e, 11'b0}, {m, 11'b0});
        @(negedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic [10:0] e);
        tick();
        push(nm, {19'b0, e}, {19'b0, 11'h7FF});
        @(negedge clk);
        #1;
    endtask

    task automatic shift2(input logic [31:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            cfg_en = 1'b1;
            cfg_in = v[k];
            tick();
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    task automatic commit2();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic shift1(input logic [7:0] v);
        for (int k = 0; k < 8; k++) begin
            c1_en = 1'b1;
            c1_in = v[k];
            tick();
        end
        c1_en = 1'b0;
        c1_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] seqv;

    initial begin
        rst = 1'b1;
        cfg_en = 0; cfg_in = 0; cfg_commit = 0;
        c1_en = 0; c1_in = 0; c1_commit = 0;
        north_in = 2'($urandom); east_in = 2'($urandom);
        south_in = 2'($urandom); west_in = 2'($urandom);
        n1_in = 1'($urandom); e1_in = 1'($urandom);
        s1_in = 1'($urandom); w1_in = 1'($urandom);
        tick();
        chk2("reset", v2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), MA);
        chk1("reset_w1", 11'b0);
        rst = 1'b0;

        // Straight N<->S; active stays zero until commit
        north_in = 2'b00; east_in = 2'b11; south_in = 2'b10; west_in = 2'b01;
        shift2(32'h0A0A, 16);
        chk2("full_before_commit", v2(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), MA);
        commit2();
        chk2("straight", v2(2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 0, 0, 0), MA);
        checks++;
        if (north_out !== 2'b10) begin
            errors++;
            $display("FAIL straight_north_out: got %b want %b", north_out, 2'b10);
        end
        checks++;
        if (north_oe !== 2'b11) begin
            errors++;
            $display("FAIL straight_north_oe: got %b want %b", north_oe, 2'b11);
        end
        checks++;
        if (east_oe !== 2'b00) begin
            errors++;
            $display("FAIL straight_east_oe: got %b want %b", east_oe, 2'b00);
        end
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL straight_cfg_err: got %b want %b", cfg_err, 1'b0);
        end

        // W=1 east ccw: track rotation wraps to track 0
        shift1(8'h0C);
        c1_commit = 1'b1; tick(); c1_commit = 1'b0;
        n1_in = 1'b1; e1_in = 1'b1; s1_in = 1'b1; w1_in = 1'b1;
        chk1("w1_ccw_hi", 11'b0100_0100_000);
        n1_in = 1'b0;
        chk1("w1_ccw_lo", 11'b0000_0100_000);

        // East ccw rotated, west clockwise
        shift2(32'h50F0, 16);
        commit2();
        north_in = 2'b01; east_in = 2'b00; south_in = 2'b11; west_in = 2'b10;
        chk2("rotate", v2(2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 0, 0, 0), MA);
        north_in = 2'b10;
        chk2("rotate2", v2(2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11, 0, 0, 0), MA);

        // Partial load: outputs hold while shifting, commit flags error
        north_in = 2'b01;
        shift2(32'h0, 10);
        chk2("no_glitch", v2(2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 0, 0, 0), MA);
        commit2();
        north_in = 2'b00; east_in = 2'b10; south_in = 2'b01; west_in = 2'b00;
        chk2("partial", v2(2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 1), MA);
        shift2(32'h0A0A, 16);
        commit2();
        north_in = 2'b11; east_in = 2'b00; south_in = 2'b01; west_in = 2'b00;
        chk2("reload_clears_err", v2(2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 0, 0, 0), MA);

        // Overflow with chain pass-through
        seqv = 32'h0000_A5C3;
        for (int n = 1; n <= 32; n++) begin
            cfg_en = 1'b1;
            cfg_in = seqv[n-1];
            tick();
            cfg_en = 1'b0;
            if (n >= 16)
                chk2("passthru", v2(0, 0, 0, 0, 0, 0, 0, 0, seqv[n-16], (n == 16), (n >= 17)), MC);
        end
        commit2();
        chk2("overflow_commit", v2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), MA);

        // Shift and commit on the same edge
        shift2(32'h0A0A, 16);
        cfg_en = 1'b1; cfg_in = 1'b1; cfg_commit = 1'b1;
        tick();
        cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
        north_in = 2'b10; south_in = 2'b01;
        chk2("shift_commit", v2(2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 1, 0, 0), MA);
        shift2(32'h0, 14);
        chk2("count_15", v2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), MC);
        shift2(32'h0, 1);
        chk2("count_16", v2(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), MC);

        // Reset mid-load discards everything
        commit2();
        shift2(32'h1F, 5);
        rst = 1'b1;
        east_in = 2'b11; west_in = 2'b11;
        chk2("rst_mid", v2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), MA);
        checks++;
        if (cfg_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_cfg_out: got %b want %b", cfg_out, 1'b0);
        end
        checks++;
        if (cfg_full !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_cfg_full: got %b want %b", cfg_full, 1'b0);
        end
        chk1("rst_mid_w1", 11'b0);
        rst = 1'b0;
        commit2();
        chk2("commit_after_rst", v2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), MA);

        // Input-to-output latency
        north_in = 2'b00; south_in = 2'b00; east_in = 2'b00; west_in = 2'b00;
        shift2(32'h0A0A, 16);
        commit2();
        chk2("lag_base", v2(2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 0, 0, 0), MA);
        tick();
        south_in = 2'b11;
`ifdef SBOX_OUTPUT_REG_EN
        push("lag_old", {v2(2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 0, 0, 0), 11'b0}, {MR, 11'b0});
`else
        push("lag_new", {v2(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 0, 0, 0), 11'b0}, {MR, 11'b0});
`endif
        @(negedge clk);
        #1;
        tick();
        push("lag_settled", {v2(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 0, 0, 0), 11'b0}, {MR, 11'b0});
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_box_param.md
Name: switch_box_param

Overview:
- Parametrised successor to the two-track switch box element. It replaces the raw gate-per-connection model with directional per-side track buses and a generic W-track routing pattern.
- Routing configuration is loaded through a serial config chain into a shadow register, then atomically committed to an active register.
- Sits in the FPGA routing fabric between CLB tiles, daisy-chained on the fabric config chain.

Parameters:
- W, 2, tracks per side (W >= 1).
- CFG_BITS, 8*W, derived localparam (4 sides x W tracks x 2 select bits); not overridable.

Ports:
- clk  input  1  fabric/config clock
- rst  input  1  asynchronous, active-high reset
- cfg_en  input  1  shift enable for config chain
- cfg_in  input  1  serial config data in
- cfg_out  output  1  serial config data out; equals shadow bit 0
- cfg_commit  input  1  one-cycle pulse; copies shadow to active
- cfg_full  output  1  high when exactly CFG_BITS bits have been shifted since the last commit or reset
- cfg_err  output  1  sticky error flag
- north_in, east_in, south_in, west_in  input  W  incoming tracks per side
- north_out, east_out, south_out, west_out  output  W  outgoing tracks per side
- north_oe, east_oe, south_oe, west_oe  output  W  per-track drive enable (feeds pad/tristate wrapper)

Behaviour:
- Reset: asynchronous, active-high. Clears shadow, active, count and cfg_err to 0. All *_out, *_oe and cfg_out read 0. Outputs remain 0 until the first commit.
- Side index: N=0, E=1, S=2, W=3.
- Field layout: sel[s][i] = active[2*(s*W+i)+1 : 2*(s*W+i)].
- Routing (combinational from active and *_in):
  - sel=0: out=0, oe=0.
  - sel=1: out=in[(s+1)%4][i], oe=1 (clockwise neighbour, same track).
  - sel=2: out=in[(s+2)%4][i], oe=1 (straight through).
  - sel=3: out=in[(s+3)%4][(i+1)%W], oe=1 (counter-clockwise, track rotated; W=1 wraps to track 0).
- Shift (cfg_en=1, rising clk):
  - shadow <= {cfg_in, shadow[CFG_BITS-1:1]}.
  - cfg_out is registered, so the first bit shifted in appears at cfg_out after CFG_BITS shifts.
  - count increments, saturating at CFG_BITS+1.
- cfg_full: count==CFG_BITS.
- Overflow: a shift when count==CFG_BITS sets cfg_err and count goes to CFG_BITS+1. Shadow still shifts, because chain pass-through must keep working.
- Commit (cfg_commit=1, rising clk):
  - active <= shadow as it was before any same-cycle shift.
  - count <= 0, or to 1 if cfg_en is also high that cycle.
  - cfg_err <= 0 if count==CFG_BITS at commit, else 1 (partial or over-length load).
- Commit does not alter shadow. Repeated commits without shifting re-load the same value and set cfg_err, since count is 0.
- Routing outputs change only on the cycle after commit. Never glitch to intermediate shadow contents.
- Reset asserted mid-shift or mid-commit: everything returns to reset state immediately. A partially loaded config is discarded.
- cfg_en=0 and cfg_commit=0: all state holds.

Optional Feature:
- Macro SBOX_OUTPUT_REG_EN.
- Defined: *_out and *_oe are registered on clk (reset 0), adding one cycle of latency from *_in or commit to outputs. This breaks combinational loops across tiles for timing and simulation.
- Undefined: outputs are purely combinational from active and *_in, with zero latency.
- Config chain timing is identical in both builds.

Decomposition:
- Package sbox_pkg holds:
  - side enum (SIDE_N..SIDE_W, 2 bits);
  - select encoding constants (SEL_OFF, SEL_CW, SEL_STRAIGHT, SEL_CCW);
  - function cfg_idx(side, track, W) returning the field LSB.
- One natural sub-module: sbox_track_mux. It takes one 2-bit select plus three W-bit source buses and produces one out/oe bit. It is instantiated 4*W times via generate.
- Config chain, counter and commit logic stay in the top module.

Test Plan:
- Reset: drive rst=1 with random *_in -> all *_out=0, *_oe=0, cfg_out=0, cfg_full=0, cfg_err=0.
- W=2 straight load: shift 16 bits giving N and S sel=2, E and W sel=0, then commit. Drive south_in=2'b10 -> north_out=2'b10, north_oe=2'b11, east_oe=2'b00. cfg_full=1 before commit and cfg_err=0 after.
- W=2 rotate: set east sel=3 and drive north_in=2'b01 -> east_out=2'b10 (track i takes north track (i+1)%2). With W=1 and sel=3 -> out equals in track 0.
- Partial load: shift 10 bits and commit -> cfg_err=1 and active equals the pre-shifted shadow. A full 16-bit load plus commit then clears cfg_err.
- Overflow and passthrough: shift 17 bits -> cfg_err set after commit. cfg_out over shifts 17..32 reproduces shifts 1..16 of cfg_in.
- Simultaneous shift and commit on the same edge -> active equals the old shadow and count=1 afterwards. Assert rst mid-load -> state is zero. With SBOX_OUTPUT_REG_EN, out lags in by exactly 1 cycle.
